// File: rtl/md5_hex_streamer_if.sv
// Character-stream interface between the digest source, the hex streamer
// and the UART transmitter. The master side is the streamer itself.
interface md5_hex_streamer_if;
  logic [127:0] digest;
  logic         digest_valid;
  logic [7:0]   bytetosend;
  logic         send;
  logic         sent;
  logic         busy;
  logic         done;

  modport master (
    input  digest,
    input  digest_valid,
    input  sent,
    output bytetosend,
    output send,
    output busy,
    output done
  );

  modport slave (
    output digest,
    output digest_valid,
    output sent,
    input  bytetosend,
    input  send,
    input  busy,
    input  done
  );
endinterface

// File: rtl/md5_hex_streamer.sv
// MD5 hex streamer: latches a 128-bit digest and hands it to the UART
// transmitter as 32 ASCII hex characters (MS nibble first), optionally
// followed by CR LF, one byte per send/sent handshake.
module md5_hex_streamer #(
  parameter bit UPPERCASE   = 1'b0,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  md5_hex_streamer_if.master bus
);

  localparam logic [5:0] LAST = APPEND_CRLF ? 6'd33 : 6'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t         r_state;
  logic [5:0]     r_index;
  logic [127:0]   r_shift;
  logic [7:0]     r_byte;
  logic           r_send;
  logic           r_busy;
  logic           r_done;

  state_t         w_state_nx;
  logic [5:0]     w_index_nx;
  logic [127:0]   w_shift_nx;
  logic [7:0]     w_byte_nx;
  logic           w_send_nx;
  logic           w_busy_nx;
  logic           w_done_nx;
  logic           w_last;

  // ASCII for a frame position: hex digit of the top nibble, or the CR/LF trailer.
  function automatic logic [7:0] char_of(input logic [5:0] idx, input logic [3:0] nib);
    logic [7:0] alpha_base;
    alpha_base = UPPERCASE ? 8'h41 : 8'h61;
    if (idx == 6'd32) begin
      char_of = 8'h0D;
    end else if (idx == 6'd33) begin
      char_of = 8'h0A;
    end else if (nib < 4'd10) begin
      char_of = 8'h30 + {4'h0, nib};
    end else begin
      char_of = alpha_base + {4'h0, nib} - 8'd10;
    end
  endfunction

  assign w_last = (r_index == LAST);

  // State, datapath and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_index <= 6'd0;
      r_shift <= 128'd0;
      r_byte  <= 8'h00;
      r_send  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_index <= w_index_nx;
      r_shift <= w_shift_nx;
      r_byte  <= w_byte_nx;
      r_send  <= w_send_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
    end
  end

  // Next state: capture only in IDLE, advance only on a sent seen in WAIT.
  always_comb begin
    w_state_nx = r_state;
    w_index_nx = r_index;
    w_shift_nx = r_shift;
    case (r_state)
      ST_IDLE: begin
        if (bus.digest_valid) begin
          w_state_nx = ST_ISSUE;
          w_index_nx = 6'd0;
          w_shift_nx = bus.digest;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.sent) begin
          if (w_last) begin
            w_state_nx = ST_IDLE;
          end else begin
            w_state_nx = ST_ISSUE;
            w_index_nx = r_index + 6'd1;
            w_shift_nx = {r_shift[123:0], 4'h0};
          end
        end else begin
          w_state_nx = ST_WAIT;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_index_nx = 6'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    w_send_nx = (w_state_nx == ST_ISSUE);
    w_busy_nx = (w_state_nx != ST_IDLE);
    w_done_nx = (r_state == ST_WAIT) && bus.sent && w_last;
    if (w_state_nx == ST_ISSUE) begin
      w_byte_nx = char_of(w_index_nx, w_shift_nx[127:124]);
    end else begin
      w_byte_nx = r_byte;
    end
  end

  assign bus.bytetosend = r_byte;
  assign bus.send       = r_send;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_md5_hex_streamer.sv
// Directed bench for md5_hex_streamer: one lowercase+CRLF instance and one
// uppercase/no-CRLF instance, driven one at a time through a shared handshake model.
`timescale 1ns/1ps
module tb_md5_hex_streamer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   sel      = 0;

  always #31.25 clock = ~clock;

  md5_hex_streamer_if if_a ();
  md5_hex_streamer_if if_b ();

  md5_hex_streamer #(.UPPERCASE(1'b0), .APPEND_CRLF(1'b1)) u_dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (if_a.master)
  );

  md5_hex_streamer #(.UPPERCASE(1'b1), .APPEND_CRLF(1'b0)) u_dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (if_b.master)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic obs_send();
    return (sel != 0) ? if_b.send : if_a.send;
  endfunction

  function automatic logic obs_busy();
    return (sel != 0) ? if_b.busy : if_a.busy;
  endfunction

  function automatic logic obs_done();
    return (sel != 0) ? if_b.done : if_a.done;
  endfunction

  function automatic logic [7:0] obs_byte();
    return (sel != 0) ? if_b.bytetosend : if_a.bytetosend;
  endfunction

  task automatic drive_sent(input logic v);
    if (sel != 0) if_b.sent = v;
    else          if_a.sent = v;
  endtask

  task automatic drive_dv(input logic v, input logic [127:0] d);
    if (sel != 0) begin
      if_b.digest_valid = v;
      if_b.digest       = d;
    end else begin
      if_a.digest_valid = v;
      if_a.digest       = d;
    end
  endtask

  // Play the transmitter for one frame: sent returns 5 cycles after each send.
  // dv_at: inject a digest_valid during that byte's WAIT; same_at: raise sent
  // together with send; stop_at: return in WAIT of that byte; final_dv: raise
  // digest_valid together with the last sent.
  task automatic run_frame(input int nbytes, input string hex, input int dv_at,
                           input int same_at, input int stop_at, input bit final_dv);
    int wait_cnt;
    logic [7:0] exp_b;
    for (int i = 0; i < nbytes; i++) begin
      wait_cnt = 0;
      while (obs_send() !== 1'b1 && wait_cnt < 20) begin
        step();
        wait_cnt++;
      end
      check32($sformatf("latency_%0d", i), wait_cnt, 0);
      check1($sformatf("send_%0d", i), obs_send(), 1'b1);
      if (i < 32)       exp_b = hex[i];
      else if (i == 32) exp_b = 8'h0D;
      else              exp_b = 8'h0A;
      check8($sformatf("byte_%0d", i), obs_byte(), exp_b);
      check1($sformatf("busy_%0d", i), obs_busy(), 1'b1);
      if (i == same_at) drive_sent(1'b1);
      step();
      drive_sent(1'b0);
      if (i == stop_at) return;
      for (int g = 1; g < 5; g++) begin
        check1($sformatf("send_pulse_%0d_%0d", i, g), obs_send(), 1'b0);
        check8($sformatf("byte_hold_%0d_%0d", i, g), obs_byte(), exp_b);
        if (i == dv_at && g == 2) drive_dv(1'b1, 128'd0);
        step();
        drive_dv(1'b0, 128'd0);
      end
      drive_sent(1'b1);
      if (final_dv && i == nbytes - 1) drive_dv(1'b1, 128'd0);
      step();
      drive_sent(1'b0);
      drive_dv(1'b0, 128'd0);
    end
    check1("done_pulse", obs_done(), 1'b1);
    check1("busy_at_done", obs_busy(), 1'b0);
    check1("send_at_done", obs_send(), 1'b0);
  endtask

  // Count sends/dones over a quiet window; a stray sent is pulsed at cycle 5.
  task automatic quiet_window(input string tag, input int cycles);
    int n_sends;
    int n_dones;
    n_sends = 0;
    n_dones = 0;
    for (int k = 0; k < cycles; k++) begin
      if (k == 5) drive_sent(1'b1);
      step();
      drive_sent(1'b0);
      if (if_a.send === 1'b1 || if_b.send === 1'b1) n_sends++;
      if (if_a.done === 1'b1 || if_b.done === 1'b1) n_dones++;
    end
    check32({tag, "_sends"}, n_sends, 0);
    check32({tag, "_dones"}, n_dones, 0);
  endtask

  initial begin
    if_a.digest = 128'd0; if_a.digest_valid = 1'b0; if_a.sent = 1'b0;
    if_b.digest = 128'd0; if_b.digest_valid = 1'b0; if_b.sent = 1'b0;

    // 1. reset for 3 cycles, then 100 idle cycles with no send
    reset = 1'b0;
    repeat (3) step();
    check8("rst_byte_a", if_a.bytetosend, 8'h00);
    check1("rst_send_a", if_a.send, 1'b0);
    check1("rst_busy_a", if_a.busy, 1'b0);
    check1("rst_done_a", if_a.done, 1'b0);
    check8("rst_byte_b", if_b.bytetosend, 8'h00);
    check1("rst_send_b", if_b.send, 1'b0);
    check1("rst_busy_b", if_b.busy, 1'b0);
    check1("rst_done_b", if_b.done, 1'b0);
    reset = 1'b1;
    sel = 0;
    quiet_window("idle", 100);

    // 2/4/5. lowercase + CRLF frame; stray digest_valid at byte 10,
    // sent together with send at byte 3, digest_valid with the final sent
    sel = 0;
    drive_dv(1'b1, 128'hd41d8cd98f00b204e9800998ecf8427e);
    step();
    drive_dv(1'b0, 128'd0);
    run_frame(34, "d41d8cd98f00b204e9800998ecf8427e", 10, 3, -1, 1'b1);
    step();
    check1("done_one_cycle", if_a.done, 1'b0);
    check1("busy_after_frame", if_a.busy, 1'b0);
    check8("byte_after_frame", if_a.bytetosend, 8'h0A);
    quiet_window("post_frame_a", 20);

    // 3. uppercase, no CRLF, all-ones digest: 32 x 'F'
    sel = 1;
    drive_dv(1'b1, {128{1'b1}});
    step();
    drive_dv(1'b0, 128'd0);
    run_frame(32, "FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF", -1, -1, -1, 1'b0);

    // digest_valid in the done cycle is accepted; abort with reset at byte 20
    drive_dv(1'b1, 128'h0123456789ABCDEFFEDCBA9876543210);
    step();
    drive_dv(1'b0, 128'd0);
    run_frame(32, "0123456789ABCDEFFEDCBA9876543210", -1, -1, 20, 1'b0);

    // 6. reset while in WAIT with a sent pending
    drive_sent(1'b1);
    reset = 1'b0;
    step();
    drive_sent(1'b0);
    check1("abort_send", if_b.send, 1'b0);
    check1("abort_busy", if_b.busy, 1'b0);
    check8("abort_byte", if_b.bytetosend, 8'h00);
    check1("abort_done", if_b.done, 1'b0);
    reset = 1'b1;
    step();
    check1("abort_send_after", if_b.send, 1'b0);
    check1("abort_busy_after", if_b.busy, 1'b0);

    drive_dv(1'b1, 128'hA5C30F1E2D4B69789ABCDEF012345678);
    step();
    drive_dv(1'b0, 128'd0);
    run_frame(32, "A5C30F1E2D4B69789ABCDEF012345678", -1, -1, -1, 1'b0);
    step();
    check1("restart_done_cleared", if_b.done, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
